// File: rtl/pr_bus_pkg.sv
// Shared word layout for the partition-engine score bus: field offsets,
// the packed score word and pack/unpack helpers.
package pr_bus_pkg;

  localparam int SCORE_W   = 24;
  localparam int NODE_W    = 6;
  localparam int VALID_BIT = 0;
  localparam int NODE_LSB  = 1;
  localparam int SCORE_LSB = 7;
  localparam int WIDTH     = 31;

  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic [NODE_W-1:0]  node;
    logic               valid;
  } word_t;

  function automatic logic [WIDTH-1:0] pack_word(input logic [SCORE_W-1:0] score,
                                                 input logic [NODE_W-1:0]  node);
    word_t w;
    w.score = score;
    w.node  = node;
    w.valid = 1'b1;
    return w;
  endfunction

  function automatic logic [NODE_W-1:0] word_node(input logic [WIDTH-1:0] w);
    return w[NODE_LSB +: NODE_W];
  endfunction

  function automatic logic [SCORE_W-1:0] word_score(input logic [WIDTH-1:0] w);
    return w[SCORE_LSB +: SCORE_W];
  endfunction

endpackage

// File: rtl/score_fifo.sv
// Per-port synchronous FIFO with async reset; a push into a full FIFO is
// accepted only when the same edge pops.
module score_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/score_bus_arbiter.sv
// Round-robin serialiser of partition-engine score words onto one broadcast
// bus, with PageRank iteration tracking. Optional macro BUBBLE_INSERT_EN
// forces an idle cycle after every broadcast word.
module score_bus_arbiter
  import pr_bus_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int WIDTH = pr_bus_pkg::WIDTH,
  parameter int DEPTH = 16,
  parameter int N     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORT-1:0]       in_write,
  input  logic [NPORT*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [NPORT-1:0]       fifo_full,
  output logic [NPORT-1:0]       overflow,
  output logic                   iter_done,
  output logic [15:0]            iter_count,
  output logic                   dup_err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NPORT-1:0] push_req;
  logic [NPORT-1:0] fifo_empty;
  logic [NPORT-1:0] pop;
  logic [NPORT-1:0] drop;
  logic [WIDTH-1:0] fifo_rdata [NPORT];
  logic [CW-1:0]    fifo_count [NPORT];

  logic [PW-1:0]    rr;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    rr_next;
  logic             grant_vld;
  logic             allow;
  logic [WIDTH-1:0] grant_word;

  logic [N-1:0]     seen;
  logic [N-1:0]     seen_set;
  logic [31:0]      node_ext;
  logic             tracked;
  logic             hit;
  logic             all_seen;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign push_req[p] = in_write[p] & in_data[p*WIDTH + VALID_BIT];
    assign drop[p]     = push_req[p] & ~pop[p] & (fifo_count[p] == CW'(DEPTH));

    score_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req[p]),
      .pop   (pop[p]),
      .wdata (in_data[p*WIDTH +: WIDTH]),
      .rdata (fifo_rdata[p]),
      .full  (fifo_full[p]),
      .empty (fifo_empty[p]),
      .count (fifo_count[p])
    );
  end

`ifdef BUBBLE_INSERT_EN
  assign allow = ~out_valid;
`else
  assign allow = 1'b1;
`endif

  // Round-robin search starting at rr, wrapping modulo NPORT.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    pop       = '0;
    idx       = 0;
    if (allow) begin
      for (int i = 0; i < NPORT; i++) begin
        idx = (int'(rr) + i) % NPORT;
        if (!grant_vld && !fifo_empty[idx]) begin
          grant_vld = 1'b1;
          grant     = PW'(idx);
        end
      end
    end
    if (grant_vld) pop[grant] = 1'b1;
  end

  assign grant_word = fifo_rdata[grant];
  assign rr_next    = (grant == PW'(NPORT-1)) ? '0 : grant + 1'b1;

  // Iteration tracker view of the word about to be broadcast.
  always_comb begin
    node_ext = 32'(word_node(grant_word));
    tracked  = grant_vld && (node_ext < 32'(N));
    hit      = 1'b0;
    seen_set = seen;
    for (int j = 0; j < N; j++) begin
      if (tracked && (node_ext == 32'(j))) begin
        hit         = seen[j];
        seen_set[j] = 1'b1;
      end
    end
    all_seen = &seen_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr         <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      iter_done  <= 1'b0;
      iter_count <= '0;
      overflow   <= '0;
      dup_err    <= 1'b0;
      seen       <= '0;
    end else begin
      overflow  <= overflow | drop;
      iter_done <= 1'b0;
      if (grant_vld) begin
        out_data  <= grant_word;
        out_valid <= 1'b1;
        rr        <= rr_next;
        if (tracked) begin
          if (hit) dup_err <= 1'b1;
          if (all_seen) begin
            seen       <= '0;
            iter_done  <= 1'b1;
            iter_count <= iter_count + 16'd1;
          end else begin
            seen <= seen_set;
          end
        end
      end else begin
        // Zero word on idle so level-sensitive consumers see a change.
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_bus_arbiter.sv
// Scoreboard bench for score_bus_arbiter: stimulus queues expected bus words,
// a negedge monitor pops and compares them as the DUT broadcasts.
module tb_score_bus_arbiter;

  localparam int NPORT = 4;
  localparam int W     = 31;

  logic               clk;
  logic               reset;
  logic [NPORT-1:0]   in_write;
  logic [NPORT*W-1:0] in_data;
  logic [W-1:0]       out_data;
  logic               out_valid;
  logic [NPORT-1:0]   fifo_full;
  logic [NPORT-1:0]   overflow;
  logic               iter_done;
  logic [15:0]        iter_count;
  logic               dup_err;

  score_bus_arbiter #(
    .NPORT (NPORT),
    .WIDTH (W),
    .DEPTH (16),
    .N     (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_write   (in_write),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .iter_done  (iter_done),
    .iter_count (iter_count),
    .dup_err    (dup_err)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [23:0] s, input logic [5:0] id);
    return {s, id, 1'b1};
  endfunction

  function automatic logic [23:0] sc(input int id);
    return 24'h010000 + 24'(id);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [W-1:0] w, input logic d);
    exp_t e;
    e.word = w;
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] wr, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_write = wr;
    in_data  = {d3, d2, d1, d0};
    @(posedge clk);
    #1;
    in_write = '0;
    in_data  = '0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every broadcast word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL unexpected_word: got %h, required no word", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.word || iter_done !== mon_e.done) begin
            fail_cnt++;
            $display("FAIL bus_word: got data=%h done=%b, required data=%h done=%b",
                     out_data, iter_done, mon_e.word, mon_e.done);
          end
        end
      end else begin
        cmp_cnt++;
        if (out_data !== '0 || iter_done !== 1'b0) begin
          fail_cnt++;
          $display("FAIL idle_zero: got data=%h done=%b, required data=0 done=0",
                   out_data, iter_done);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_write = '0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_iter_count", {16'd0, iter_count}, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dup_err", {31'd0, dup_err}, 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    reset = 1'b0;
    #1;

    // Reset mid-burst: only a0 escapes before reset hits between edges.
    expect_word(mk(24'hAA0000, 6'd0), 1'b0);
    drive(4'b0011, mk(24'hAA0000, 6'd0), mk(24'hBB0000, 6'd1), '0, '0);
    drive(4'b0011, mk(24'hAA0001, 6'd2), mk(24'hBB0001, 6'd3), '0, '0);
    drive(4'b0011, mk(24'hAA0002, 6'd4), mk(24'hBB0002, 6'd5), '0, '0);
    reset = 1'b1;
    #1;
    check("midburst_out_data", 32'(out_data), 32'd0);
    check("midburst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midburst_nothing_left", 32'(exp_q.size()), 32'd0);

    // Single word from port 2; invalid-bit write on port 0 is ignored.
    expect_word({24'h040000, 6'd5, 1'b1}, 1'b0);
    drive(4'b0101, {24'h777777, 6'd9, 1'b0}, '0, {24'h040000, 6'd5, 1'b1}, '0);
    drain(20, "single_drain");

    // Contention from rr=0, then winner search must restart at port 0.
    do_reset();
    for (int p = 0; p < 4; p++) expect_word(mk(24'h200000 + 24'(p), 6'(10 + p)), 1'b0);
    drive(4'b1111, mk(24'h200000, 6'd10), mk(24'h200001, 6'd11),
          mk(24'h200002, 6'd12), mk(24'h200003, 6'd13));
    drain(20, "contention_drain");
    expect_word(mk(24'h300000, 6'd20), 1'b0);
    expect_word(mk(24'h300003, 6'd23), 1'b0);
    drive(4'b1001, mk(24'h300000, 6'd20), '0, '0, mk(24'h300003, 6'd23));
    drain(20, "rr_wrap_drain");

`ifndef BUBBLE_INSERT_EN
    // Overflow: ports 0,2,3 send 8 words each while port 1 sends 22; port 1's
    // round-robin share leaves it full after edge 20, so word 21 is dropped.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      expect_word(mk(24'h0A0000 + 24'(j), 6'(j)), 1'b0);
      expect_word(mk(24'h0B0000 + 24'(j), 6'(j)), 1'b0);
      expect_word(mk(24'h0C0000 + 24'(j), 6'(j)), 1'b0);
      expect_word(mk(24'h0D0000 + 24'(j), 6'(j)), 1'b0);
    end
    for (int j = 8; j < 21; j++) expect_word(mk(24'h0B0000 + 24'(j), 6'(j)), 1'b0);
    for (int k = 0; k < 22; k++) begin
      drive((k < 8) ? 4'b1111 : 4'b0010,
            mk(24'h0A0000 + 24'(k), 6'(k)), mk(24'h0B0000 + 24'(k), 6'(k)),
            mk(24'h0C0000 + 24'(k), 6'(k)), mk(24'h0D0000 + 24'(k), 6'(k)));
      if (k == 20) check("ovf_fifo_full", 32'(fifo_full), 32'h2);
    end
    drain(200, "overflow_drain");
    check("ovf_sticky", 32'(overflow), 32'h2);
`endif

    // Iteration: ids 0..63, port p owns ids 16p..16p+15; id 63 completes.
    do_reset();
    for (int j = 0; j < 16; j++)
      for (int p = 0; p < 4; p++)
        expect_word(mk(sc(p*16 + j), 6'(p*16 + j)), (p == 3 && j == 15));
    for (int j = 0; j < 16; j++)
      drive(4'b1111, mk(sc(j), 6'(j)), mk(sc(16 + j), 6'(16 + j)),
            mk(sc(32 + j), 6'(32 + j)), mk(sc(48 + j), 6'(48 + j)));
    drain(200, "iter_drain");
    check("iter_count_1", {16'd0, iter_count}, 32'd1);
    check("iter_dup_clear", {31'd0, dup_err}, 32'd0);
    check("iter_no_overflow", 32'(overflow), 32'd0);
    expect_word(mk(sc(7), 6'd7), 1'b0);
    expect_word(mk(sc(7), 6'd7), 1'b0);
    drive(4'b0001, mk(sc(7), 6'd7), '0, '0, '0);
    drive(4'b0001, mk(sc(7), 6'd7), '0, '0, '0);
    drain(20, "dup_drain");
    check("dup_err_set", {31'd0, dup_err}, 32'd1);
    check("iter_count_held", {16'd0, iter_count}, 32'd1);

`ifdef BUBBLE_INSERT_EN
    // Two queued words must broadcast as valid, idle, valid.
    expect_word(mk(24'h500000, 6'd40), 1'b0);
    expect_word(mk(24'h500001, 6'd41), 1'b0);
    drive(4'b0011, mk(24'h500000, 6'd40), mk(24'h500001, 6'd41), '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bubble_v0", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #1;
    check("bubble_v1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("bubble_v2", {31'd0, out_valid}, 32'd1);
    drain(20, "bubble_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
